// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and sizing helpers for the UART Tx arbiter
// Contents: controller state encoding, counter width helpers, default Busy timeout.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEFAULT_BUSY_TIMEOUT = 64;

    // Byte counter never narrower than one bit, even for a one-byte word.
    function automatic int bcnt_width(input int num_bytes);
        return (num_bytes <= 2) ? 1 : $clog2(num_bytes);
    endfunction

    function automatic int tcnt_width(input int busy_timeout);
        return (busy_timeout <= 2) ? 1 : $clog2(busy_timeout);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin arbiter with pointer update on done
// Ports: clk_i/reset_i (sync, active-high), req_i[1:0] requests, done_i strobe with
//        done_idx_i (index just served), gnt_valid_o/gnt_idx_o combinational grant.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_idx_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // ptr_q names the requester that wins a tie; 0 after reset.
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        // Favour whichever requester was not just served.
        if (done_i) begin
            ptr_d = ~done_idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_valid_o = |req_i;

    always_comb begin
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ptr_q;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART Tx between two word requesters
// Ports: CLK, Reset (sync, active-high); Req0/Data0/Ack0 and Req1/Data1/Ack1 word
//        requesters; Busy from the UART; Tx_valid/TX_Data byte strobe to the UART;
//        Grant, Ctrl_busy, Timeout_err status. All outputs are registered.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int width        = 8,
    parameter int NUM_BYTES    = 2,
    parameter int MSB_FIRST    = 0,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Req0,
    input  logic [width*NUM_BYTES-1:0]   Data0,
    output logic                         Ack0,
    input  logic                         Req1,
    input  logic [width*NUM_BYTES-1:0]   Data1,
    output logic                         Ack1,
    input  logic                         Busy,
    output logic                         Tx_valid,
    output logic [width-1:0]             TX_Data,
    output logic                         Grant,
    output logic                         Ctrl_busy,
    output logic                         Timeout_err
);

    localparam int WORD_W = width * NUM_BYTES;
    localparam int BW     = bcnt_width(NUM_BYTES);
    localparam int TW     = tcnt_width(BUSY_TIMEOUT);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TIMEOUT - 1);

    // The byte on the wire always sits at the leading end of the shift register.
    function automatic logic [width-1:0] head_byte(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WORD_W-1 -: width];
        end
        return w[width-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << width;
        end
        return w >> width;
    endfunction

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [width-1:0]    tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                terr_q, terr_d;
    logic                grant_q, grant_d;
    logic                cbusy_q, cbusy_d;

    logic                gnt_valid, gnt_idx;
    logic [WORD_W-1:0]   picked_word;
    logic [WORD_W-1:0]   shifted_word;

    rr_arbiter_2 u_arb (
        .clk_i       (CLK),
        .reset_i     (Reset),
        .req_i       ({Req1, Req0}),
        .done_i      (state_q == DONE),
        .done_idx_i  (grant_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign picked_word  = gnt_idx ? Data1 : Data0;
    assign shifted_word = advance(shreg_q);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = '0;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        terr_d     = 1'b0;
        grant_d    = grant_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    shreg_d   = picked_word;
                    tx_data_d = head_byte(picked_word);
                    grant_d   = gnt_idx;
                    bcnt_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Never strobe while the UART still reports busy.
                if (!Busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (Busy) begin
                    state_d = WAIT_LO;
                end else if (tcnt_q == TO_LAST) begin
                    // UART missed the strobe: re-issue the same byte.
                    terr_d  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!Busy) begin
                    if (bcnt_q < LAST_BYTE) begin
                        shreg_d   = shifted_word;
                        tx_data_d = head_byte(shifted_word);
                        bcnt_d    = bcnt_q + 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        // Ack is registered, so it is high for the DONE cycle.
                        ack0_d  = ~grant_q;
                        ack1_d  = grant_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cbusy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            terr_q     <= 1'b0;
            grant_q    <= 1'b0;
            cbusy_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            terr_q     <= terr_d;
            grant_q    <= grant_d;
            cbusy_q    <= cbusy_d;
        end
    end

    assign Ack0        = ack0_q;
    assign Ack1        = ack1_q;
    assign Tx_valid    = tx_valid_q;
    assign TX_Data     = tx_data_q;
    assign Grant       = grant_q;
    assign Ctrl_busy   = cbusy_q;
    assign Timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instance A: LSB first, two bytes, short timeout
    logic        a_req0 = 0, a_req1 = 0, a_busy = 0;
    logic [15:0] a_data0 = '0, a_data1 = '0;
    logic        a_ack0, a_ack1, a_txv, a_grant, a_cbusy, a_terr;
    logic [7:0]  a_txd;

    uart_tx_arbiter #(.width(8), .NUM_BYTES(2), .MSB_FIRST(0), .BUSY_TIMEOUT(8)) dut_a (
        .CLK(clk), .Reset(rst),
        .Req0(a_req0), .Data0(a_data0), .Ack0(a_ack0),
        .Req1(a_req1), .Data1(a_data1), .Ack1(a_ack1),
        .Busy(a_busy), .Tx_valid(a_txv), .TX_Data(a_txd),
        .Grant(a_grant), .Ctrl_busy(a_cbusy), .Timeout_err(a_terr)
    );

    // Instance M: MSB first, three bytes
    logic        m_req0 = 0, m_req1 = 0, m_busy = 0;
    logic [23:0] m_data0 = '0, m_data1 = '0;
    logic        m_ack0, m_ack1, m_txv, m_grant, m_cbusy, m_terr;
    logic [7:0]  m_txd;

    uart_tx_arbiter #(.width(8), .NUM_BYTES(3), .MSB_FIRST(1), .BUSY_TIMEOUT(64)) dut_m (
        .CLK(clk), .Reset(rst),
        .Req0(m_req0), .Data0(m_data0), .Ack0(m_ack0),
        .Req1(m_req1), .Data1(m_data1), .Ack1(m_ack1),
        .Busy(m_busy), .Tx_valid(m_txv), .TX_Data(m_txd),
        .Grant(m_grant), .Ctrl_busy(m_cbusy), .Timeout_err(m_terr)
    );

    logic [7:0] a_exp_b[$];
    int         a_exp_ack[$];
    int         terr_cyc[$];
    logic [7:0] m_exp_b[$];
    int cyc = 0, fall_cyc = 0;
    int a_tx_cnt = 0, a_terr_cnt = 0, m_ack0_cnt = 0, m_ack1_cnt = 0;
    logic a_mode = 1, a_hold = 0, chk_fall = 0;

    // Monitor + UART model for A: Busy high for 10 cycles per strobe.
    initial begin : mon_a
        int left, idx;
        logic was;
        left = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (a_txv) begin
                a_tx_cnt++;
                if (chk_fall) begin
                    check_eq("tx_after_busy_fall", cyc - fall_cyc, 1);
                    chk_fall = 0;
                end
                check_eq("tx_expected", int'(a_exp_b.size() != 0), 1);
                if (a_exp_b.size() != 0) check_eq("tx_byte", int'(a_txd), int'(a_exp_b.pop_front()));
            end
            if (a_ack0 || a_ack1) begin
                check_eq("ack_expected", int'(a_exp_ack.size() != 0), 1);
                if (a_exp_ack.size() != 0) begin
                    idx = a_exp_ack.pop_front();
                    check_eq("ack_idx", int'(a_ack1), idx);
                    check_eq("grant_at_ack", int'(a_grant), idx);
                end
                if (a_ack0) a_req0 = 0;
                if (a_ack1) a_req1 = 0;
            end
            if (a_terr) begin
                a_terr_cnt++;
                terr_cyc.push_back(cyc);
            end
            was = a_busy;
            if (a_hold) begin a_busy = 1; left = 0; end
            else if (left > 0) begin left--; a_busy = (left != 0); end
            else if (a_txv && a_mode) begin a_busy = 1; left = 10; end
            else a_busy = 0;
            if (was && !a_busy) fall_cyc = cyc;
        end
    end

    initial begin : mon_m
        int left;
        left = 0;
        forever begin
            @(posedge clk); #1;
            if (m_txv) begin
                check_eq("m_tx_expected", int'(m_exp_b.size() != 0), 1);
                if (m_exp_b.size() != 0) check_eq("m_tx_byte", int'(m_txd), int'(m_exp_b.pop_front()));
            end
            if (m_ack0) begin m_ack0_cnt++; m_req0 = 0; end
            if (m_ack1) m_ack1_cnt++;
            if (left > 0) begin left--; m_busy = (left != 0); end
            else if (m_txv) begin m_busy = 1; left = 10; end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_a_idle(input string tag);
        for (int i = 0; i < 400 && (a_req0 || a_req1); i++) step(1);
        check_eq(tag, int'(a_req0 || a_req1), 0);
    endtask

    task automatic wait_a_tx(input int t0);
        for (int i = 0; i < 100 && a_tx_cnt == t0; i++) step(1);
        check_eq("tx_seen", int'(a_tx_cnt != t0), 1);
    endtask

    task automatic push_word_a(input logic [15:0] w, input int who);
        a_exp_b.push_back(w[7:0]);
        a_exp_b.push_back(w[15:8]);
        a_exp_ack.push_back(who);
    endtask

    initial begin : stim
        int t0;
        // Both requesters high from reset: 0 wins the tie, then 1.
        a_data0 = 16'h1111; a_data1 = 16'h2222;
        push_word_a(16'h1111, 0); push_word_a(16'h2222, 1);
        a_req0 = 1; a_req1 = 1;
        step(3);
        check_eq("rst_outputs_a", int'({a_txv, a_txd, a_grant, a_cbusy, a_ack0, a_ack1, a_terr}), 0);
        check_eq("rst_outputs_m", int'({m_txv, m_txd, m_grant, m_cbusy, m_ack0, m_ack1, m_terr}), 0);
        rst = 0;
        wait_a_idle("tie_done");
        // Re-request both: pointer favours 0 again after serving 1.
        push_word_a(16'h1111, 0); push_word_a(16'h2222, 1);
        a_req0 = 1; a_req1 = 1;
        wait_a_idle("tie_again_done");

        // Single requester, data changed after grant is ignored.
        a_data0 = 16'hA55A;
        push_word_a(16'hA55A, 0);
        t0 = a_tx_cnt;
        a_req0 = 1;
        wait_a_tx(t0);
        a_data0 = 16'hFFFF;
        wait_a_idle("single_done");
        check_eq("single_tx_pulses", a_tx_cnt - t0, 2);

        // UART busy when Req1 arrives: no strobe until Busy falls.
        a_hold = 1;
        step(1);
        a_data1 = 16'hBEEF;
        push_word_a(16'hBEEF, 1);
        t0 = a_tx_cnt;
        a_req1 = 1;
        step(30);
        check_eq("no_tx_while_busy", a_tx_cnt - t0, 0);
        check_eq("ctrl_busy_in_issue", int'(a_cbusy), 1);
        chk_fall = 1;
        a_hold = 0;
        wait_a_idle("busy_hold_done");
        check_eq("busy_fall_checked", int'(chk_fall), 0);

        // Reset in WAIT_LO of byte 0: word restarts from the low byte.
        a_data0 = 16'hA55A;
        push_word_a(16'hA55A, 0);
        t0 = a_tx_cnt;
        a_req0 = 1;
        wait_a_tx(t0);
        step(1);
        rst = 1;
        a_exp_b.delete();
        a_exp_b.push_back(8'h5A);
        a_exp_b.push_back(8'hA5);
        step(1);
        check_eq("midreset_outputs", int'({a_txv, a_cbusy, a_ack0, a_ack1}), 0);
        check_eq("midreset_no_ack", int'(a_exp_ack.size()), 1);
        rst = 0;
        wait_a_idle("restart_done");
        check_eq("restart_tx_pulses", a_tx_cnt - t0, 3);

        // UART never raises Busy: retry every 9 cycles with the same byte.
        a_mode = 0;
        terr_cyc.delete();
        repeat (4) a_exp_b.push_back(8'h5A);
        t0 = a_terr_cnt;
        a_req0 = 1;
        for (int i = 0; i < 200 && a_terr_cnt < t0 + 3; i++) step(1);
        check_eq("terr_count", a_terr_cnt - t0, 3);
        step(1);
        check_eq("terr_period_1", terr_cyc[1] - terr_cyc[0], 9);
        check_eq("terr_period_2", terr_cyc[2] - terr_cyc[1], 9);
        rst = 1; a_req0 = 0;
        step(1);
        rst = 0;
        a_mode = 1;
        check_eq("retry_bytes_all_seen", int'(a_exp_b.size()), 0);
        check_eq("timeout_no_ack", int'(a_exp_ack.size()), 0);
        check_eq("ctrl_busy_after_reset", int'(a_cbusy), 0);

        // MSB first, three bytes.
        m_data0 = 24'h123456;
        m_exp_b.push_back(8'h12); m_exp_b.push_back(8'h34); m_exp_b.push_back(8'h56);
        m_req0 = 1;
        for (int i = 0; i < 400 && m_req0; i++) step(1);
        step(3);
        check_eq("m_ack0_count", m_ack0_cnt, 1);
        check_eq("m_ack1_count", m_ack1_cnt, 0);
        check_eq("m_bytes_all_seen", int'(m_exp_b.size()), 0);
        check_eq("a_scoreboard_empty", int'(a_exp_b.size() + a_exp_ack.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
